// File: rtl/chip8_alu_sequencer_pkg.sv
// Shared types for the Chip-8 8XYN arithmetic sequencer.
// Holds the ALU function enum, sequencer states, opcode/N codes and decode bundle.
package chip8_alu_sequencer_pkg;

   typedef enum logic [2:0] {
      ALU_f_OR,
      ALU_f_AND,
      ALU_f_XOR,
      ALU_f_ADD,
      ALU_f_MINUS,
      ALU_f_RSHIFT,
      ALU_f_LSHIFT
   } ALU_f;

   typedef enum logic [2:0] {
      IDLE,
      RD_X,
      RD_Y,
      EXEC,
      WB_X,
      WB_F,
      ERR
   } seq_state_t;

   typedef enum logic [2:0] {
      FLAG_ZERO,
      FLAG_BIT8,
      FLAG_NOT15,
      FLAG_SRC0,
      FLAG_SRC7
   } flag_src_t;

   localparam logic [3:0] OP_ARITH = 4'h8;
   localparam logic [3:0] N_LD     = 4'h0;
   localparam logic [3:0] N_OR     = 4'h1;
   localparam logic [3:0] N_AND    = 4'h2;
   localparam logic [3:0] N_XOR    = 4'h3;
   localparam logic [3:0] N_ADD    = 4'h4;
   localparam logic [3:0] N_SUB    = 4'h5;
   localparam logic [3:0] N_SHR    = 4'h6;
   localparam logic [3:0] N_SUBN   = 4'h7;
   localparam logic [3:0] N_SHL    = 4'hE;

   typedef struct packed {
      ALU_f      alu_sel;
      logic      swap_operands;
      logic      zero_in1;
      flag_src_t flag_src;
      logic      writes_vf;
      logic      legal;
   } arith_dec_t;

endpackage

// File: rtl/chip8_alu_sequencer_if.sv
// Bundle between the sequencer, decode stage, register file and ALU.
// master: sequencer side; slave: CPU/regfile/ALU side.
interface chip8_alu_sequencer_if;

   logic        start;
   logic [15:0] opcode;
   logic        busy;
   logic        done;
   logic        illegal;
   logic [3:0]  reg_raddr;
   logic [7:0]  reg_rdata;
   logic        reg_we;
   logic [3:0]  reg_waddr;
   logic [7:0]  reg_wdata;
   logic [15:0] alu_in1;
   logic [15:0] alu_in2;
   chip8_alu_sequencer_pkg::ALU_f alu_sel;
   logic [15:0] alu_out;

   modport master (
      input  start, opcode, reg_rdata, alu_out,
      output busy, done, illegal,
      output reg_raddr, reg_we, reg_waddr, reg_wdata,
      output alu_in1, alu_in2, alu_sel
   );

   modport slave (
      output start, opcode, reg_rdata, alu_out,
      input  busy, done, illegal,
      input  reg_raddr, reg_we, reg_waddr, reg_wdata,
      input  alu_in1, alu_in2, alu_sel
   );

endinterface

// File: rtl/chip8_arith_decode.sv
// Combinational decode of the 8XYN low nibble into ALU/flag controls.
// Ports: n_i (N nibble) -> dec_o (sel, swap, zero_in1, flag_src, writes_vf, legal).
module chip8_arith_decode
   import chip8_alu_sequencer_pkg::*;
#(
   parameter bit QUIRK_SHIFT_VY  = 1'b0,
   parameter bit QUIRK_LOGIC_VF0 = 1'b0
) (
   input  logic [3:0] n_i,
   output arith_dec_t dec_o
);

   always_comb begin
      dec_o.alu_sel       = ALU_f_OR;
      dec_o.swap_operands = 1'b0;
      dec_o.zero_in1      = 1'b0;
      dec_o.flag_src      = FLAG_ZERO;
      dec_o.writes_vf     = 1'b0;
      dec_o.legal         = 1'b0;
      case (n_i)
         N_LD: begin
            dec_o.legal    = 1'b1;
            dec_o.zero_in1 = 1'b1;
         end
         N_OR, N_AND, N_XOR: begin
            dec_o.legal     = 1'b1;
            dec_o.writes_vf = QUIRK_LOGIC_VF0;
            dec_o.alu_sel   = (n_i == N_OR)  ? ALU_f_OR :
                              (n_i == N_AND) ? ALU_f_AND : ALU_f_XOR;
         end
         N_ADD: begin
            dec_o.legal     = 1'b1;
            dec_o.alu_sel   = ALU_f_ADD;
            dec_o.flag_src  = FLAG_BIT8;
            dec_o.writes_vf = 1'b1;
         end
         N_SUB, N_SUBN: begin
            dec_o.legal         = 1'b1;
            dec_o.alu_sel       = ALU_f_MINUS;
            dec_o.swap_operands = (n_i == N_SUBN);
            dec_o.flag_src      = FLAG_NOT15;
            dec_o.writes_vf     = 1'b1;
         end
         N_SHR, N_SHL: begin
            dec_o.legal         = 1'b1;
            dec_o.swap_operands = QUIRK_SHIFT_VY;
            dec_o.writes_vf     = 1'b1;
            dec_o.alu_sel  = (n_i == N_SHR) ? ALU_f_RSHIFT : ALU_f_LSHIFT;
            dec_o.flag_src = (n_i == N_SHR) ? FLAG_SRC0 : FLAG_SRC7;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/chip8_alu_sequencer.sv
// Multi-cycle sequencer for Chip-8 8XYN ops: read VX/VY, drive ALU, write VX then VF.
// Ports: clk, reset_n (async active-low), io (master: start/opcode, regfile, ALU).
module chip8_alu_sequencer
   import chip8_alu_sequencer_pkg::*;
#(
   parameter logic [3:0] VF_INDEX        = 4'hF,
   parameter bit         QUIRK_SHIFT_VY  = 1'b0,
   parameter bit         QUIRK_LOGIC_VF0 = 1'b0
) (
   input logic                   clk,
   input logic                   reset_n,
   chip8_alu_sequencer_if.master io
);

   seq_state_t state_q, state_d;
   logic [3:0] x_q, x_d, y_q, y_d, n_q, n_d;
   logic [7:0] vx_q, vx_d, res_q, res_d;
   logic       flag_q, flag_d;

   logic [3:0] dec_n;
   arith_dec_t dec;
   logic [7:0] opa, opb;
   logic       is_shift;
   logic       unused_alu;

   // Legality is checked on the live opcode while idle, on the latched N after.
   assign dec_n      = (state_q == IDLE) ? io.opcode[3:0] : n_q;
   assign unused_alu = ^io.alu_out[14:9];

   chip8_arith_decode #(
      .QUIRK_SHIFT_VY (QUIRK_SHIFT_VY),
      .QUIRK_LOGIC_VF0(QUIRK_LOGIC_VF0)
   ) u_dec (
      .n_i  (dec_n),
      .dec_o(dec)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         n_q     <= '0;
         vx_q    <= '0;
         res_q   <= '0;
         flag_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         n_q     <= n_d;
         vx_q    <= vx_d;
         res_q   <= res_d;
         flag_q  <= flag_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      x_d          = x_q;
      y_d          = y_q;
      n_d          = n_q;
      vx_d         = vx_q;
      res_d        = res_q;
      flag_d       = flag_q;
      opa          = dec.swap_operands ? io.reg_rdata : vx_q;
      opb          = dec.swap_operands ? vx_q : io.reg_rdata;
      is_shift     = (dec.alu_sel == ALU_f_RSHIFT) ||
                     (dec.alu_sel == ALU_f_LSHIFT);
      io.busy      = (state_q != IDLE);
      io.done      = 1'b0;
      io.illegal   = 1'b0;
      io.reg_raddr = '0;
      io.reg_we    = 1'b0;
      io.reg_waddr = '0;
      io.reg_wdata = '0;
      io.alu_in1   = '0;
      io.alu_in2   = '0;
      io.alu_sel   = ALU_f_OR;
      case (state_q)
         IDLE: begin
            if (io.start) begin
               if (io.opcode[15:12] == OP_ARITH && dec.legal) begin
                  x_d     = io.opcode[11:8];
                  y_d     = io.opcode[7:4];
                  n_d     = io.opcode[3:0];
                  state_d = RD_X;
               end else begin
                  state_d = ERR;
               end
            end
         end
         RD_X: begin
            io.reg_raddr = x_q;
            state_d      = RD_Y;
         end
         RD_Y: begin
            // VX read issued in RD_X returns now.
            io.reg_raddr = y_q;
            vx_d         = io.reg_rdata;
            state_d      = EXEC;
         end
         EXEC: begin
            io.alu_sel = dec.alu_sel;
            io.alu_in1 = dec.zero_in1 ? 16'h0000 : {8'h00, opa};
            io.alu_in2 = is_shift ? 16'h0001 : {8'h00, opb};
            res_d      = io.alu_out[7:0];
            case (dec.flag_src)
               FLAG_BIT8:  flag_d = io.alu_out[8];
               FLAG_NOT15: flag_d = ~io.alu_out[15];
               FLAG_SRC0:  flag_d = opa[0];
               FLAG_SRC7:  flag_d = opa[7];
               default:    flag_d = 1'b0;
            endcase
            state_d = WB_X;
         end
         WB_X: begin
            io.reg_we    = 1'b1;
            io.reg_waddr = x_q;
            io.reg_wdata = res_q;
            if (dec.writes_vf) begin
               state_d = WB_F;
            end else begin
               io.done = 1'b1;
               state_d = IDLE;
            end
         end
         WB_F: begin
            // Lands after WB_X, so VF as destination ends up holding the flag.
            io.reg_we    = 1'b1;
            io.reg_waddr = VF_INDEX;
            io.reg_wdata = {7'b0, flag_q};
            io.done      = 1'b1;
            state_d      = IDLE;
         end
         ERR: begin
            io.done    = 1'b1;
            io.illegal = 1'b1;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_chip8_alu_sequencer.sv
// Directed scoreboard bench for chip8_alu_sequencer (default and quirk instances).
// Models the register file and ALU; expected writes are queued and popped on reg_we.
module tb_chip8_alu_sequencer;
   import chip8_alu_sequencer_pkg::*;

   typedef struct packed {
      logic [3:0] a;
      logic [7:0] d;
   } wr_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   chip8_alu_sequencer_if if0 ();
   chip8_alu_sequencer_if if1 ();

   chip8_alu_sequencer #(
      .VF_INDEX(4'hF), .QUIRK_SHIFT_VY(1'b0), .QUIRK_LOGIC_VF0(1'b0)
   ) dut0 (
      .clk(clk), .reset_n(reset_n), .io(if0.master)
   );

   chip8_alu_sequencer #(
      .VF_INDEX(4'hF), .QUIRK_SHIFT_VY(1'b1), .QUIRK_LOGIC_VF0(1'b1)
   ) dut1 (
      .clk(clk), .reset_n(reset_n), .io(if1.master)
   );

   logic [7:0] rf0 [16];
   logic [7:0] rf1 [16];
   logic       pl_we = 1'b0;
   logic       pl_w = 1'b0;
   logic [3:0] pl_a = '0;
   logic [7:0] pl_d = '0;

   wr_t expq [$];
   int  n_pass = 0;
   int  n_chk = 0;

   function automatic logic [15:0] alu_f(input ALU_f s,
                                         input logic [15:0] a,
                                         input logic [15:0] b);
      case (s)
         ALU_f_OR:     return a | b;
         ALU_f_AND:    return a & b;
         ALU_f_XOR:    return a ^ b;
         ALU_f_ADD:    return a + b;
         ALU_f_MINUS:  return a - b;
         ALU_f_RSHIFT: return a >> b;
         ALU_f_LSHIFT: return a << b;
         default:      return 16'h0000;
      endcase
   endfunction

   always_comb if0.alu_out = alu_f(if0.alu_sel, if0.alu_in1, if0.alu_in2);
   always_comb if1.alu_out = alu_f(if1.alu_sel, if1.alu_in1, if1.alu_in2);

   always @(posedge clk) begin
      if0.reg_rdata <= rf0[if0.reg_raddr];
      if1.reg_rdata <= rf1[if1.reg_raddr];
      if (if0.reg_we) rf0[if0.reg_waddr] <= if0.reg_wdata;
      if (if1.reg_we) rf1[if1.reg_waddr] <= if1.reg_wdata;
      if (pl_we && !pl_w) rf0[pl_a] <= pl_d;
      if (pl_we && pl_w) rf1[pl_a] <= pl_d;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic drive(input bit w, input logic s, input logic [15:0] op);
      if (w) begin
         if1.start = s;
         if1.opcode = op;
      end else begin
         if0.start = s;
         if0.opcode = op;
      end
   endtask

   task automatic snap(input bit w, output logic we, output logic [3:0] wa,
                       output logic [7:0] wd, output logic dn,
                       output logic il, output logic bz);
      if (w) begin
         we = if1.reg_we; wa = if1.reg_waddr; wd = if1.reg_wdata;
         dn = if1.done; il = if1.illegal; bz = if1.busy;
      end else begin
         we = if0.reg_we; wa = if0.reg_waddr; wd = if0.reg_wdata;
         dn = if0.done; il = if0.illegal; bz = if0.busy;
      end
   endtask

   function automatic logic [7:0] rfv(input bit w, input logic [3:0] a);
      return w ? rf1[a] : rf0[a];
   endfunction

   task automatic preload(input bit w, input logic [3:0] a, input logic [7:0] d);
      pl_w = w; pl_a = a; pl_d = d; pl_we = 1'b1;
      @(posedge clk);
      #1 pl_we = 1'b0;
      @(negedge clk);
   endtask

   task automatic push(input logic [3:0] a, input logic [7:0] d);
      wr_t e;
      e.a = a;
      e.d = d;
      expq.push_back(e);
   endtask

   // Entered just after a negedge with the DUT idle.
   task automatic run_op(input bit w, input logic [15:0] op, input int exp_done,
                         input logic exp_ill, input bit poke, input string tag);
      int cyc, nwr, nexp;
      logic got, we, dn, il, bz;
      logic [3:0] wa;
      logic [7:0] wd;
      wr_t e;
      nexp = expq.size();
      cyc = 0; nwr = 0; got = 1'b0;
      drive(w, 1'b1, op);
      @(posedge clk);
      #1 drive(w, 1'b0, op);
      while (!got && cyc < 12) begin
         @(negedge clk);
         cyc++;
         if (poke && cyc == 2) drive(w, 1'b1, 16'h0000);
         if (poke && cyc == 3) drive(w, 1'b0, 16'h0000);
         snap(w, we, wa, wd, dn, il, bz);
         if (cyc == 1) chk({tag, " busy"}, bz, 1'b1);
         if (we) begin
            nwr++;
            if (expq.size() > 0) begin
               e = expq.pop_front();
               chk({tag, " waddr"}, wa, e.a);
               chk({tag, " wdata"}, wd, e.d);
            end
         end
         if (dn) begin
            got = 1'b1;
            chk({tag, " done cycle"}, cyc, exp_done);
            chk({tag, " illegal"}, il, exp_ill);
         end
      end
      chk({tag, " done seen"}, got, 1'b1);
      chk({tag, " write count"}, nwr, nexp);
      expq.delete();
      @(negedge clk);
      snap(w, we, wa, wd, dn, il, bz);
      chk({tag, " idle busy"}, bz, 1'b0);
      chk({tag, " idle done"}, dn, 1'b0);
   endtask

   initial begin
      logic we, dn, il, bz;
      logic [3:0] wa;
      logic [7:0] wd;
      drive(1'b0, 1'b0, 16'h0000);
      drive(1'b1, 1'b0, 16'h0000);
      #2;
      chk("rst busy", if0.busy, 1'b0);
      chk("rst done", if0.done, 1'b0);
      chk("rst illegal", if0.illegal, 1'b0);
      chk("rst we", if0.reg_we, 1'b0);
      chk("rst raddr", if0.reg_raddr, 4'h0);
      chk("rst waddr", if0.reg_waddr, 4'h0);
      chk("rst wdata", if0.reg_wdata, 8'h00);
      chk("rst alu_in1", if0.alu_in1, 16'h0000);
      chk("rst alu_in2", if0.alu_in2, 16'h0000);
      chk("rst alu_sel", if0.alu_sel, ALU_f_OR);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      preload(0, 4'h1, 8'hFF); preload(0, 4'h2, 8'h01);
      push(4'h1, 8'h00); push(4'hF, 8'h01);
      run_op(0, 16'h8124, 5, 1'b0, 0, "add wrap");
      chk("add wrap V1", rfv(0, 4'h1), 8'h00);
      chk("add wrap VF", rfv(0, 4'hF), 8'h01);

      preload(0, 4'h3, 8'h05); preload(0, 4'h4, 8'h07);
      push(4'h3, 8'hFE); push(4'hF, 8'h00);
      run_op(0, 16'h8345, 5, 1'b0, 0, "sub borrow");
      chk("sub borrow V3", rfv(0, 4'h3), 8'hFE);

      preload(0, 4'h3, 8'h07); preload(0, 4'h4, 8'h07);
      push(4'h3, 8'h00); push(4'hF, 8'h01);
      run_op(0, 16'h8345, 5, 1'b0, 1, "sub equal+busy start");
      chk("sub equal VF", rfv(0, 4'hF), 8'h01);

      preload(0, 4'h5, 8'h81);
      push(4'h5, 8'h02); push(4'hF, 8'h01);
      run_op(0, 16'h850E, 5, 1'b0, 0, "shl");

      preload(0, 4'hF, 8'h10); preload(0, 4'h2, 8'h20);
      push(4'hF, 8'h30); push(4'hF, 8'h00);
      run_op(0, 16'h8F24, 5, 1'b0, 0, "add into VF");
      chk("add into VF final", rfv(0, 4'hF), 8'h00);

      run_op(0, 16'h812A, 1, 1'b1, 0, "illegal N");
      run_op(0, 16'h7123, 1, 1'b1, 0, "illegal class");

      preload(0, 4'h1, 8'hF0); preload(0, 4'h2, 8'h3C);
      preload(0, 4'hF, 8'hAA);
      push(4'h1, 8'h30);
      run_op(0, 16'h8122, 4, 1'b0, 0, "and");
      chk("and VF kept", rfv(0, 4'hF), 8'hAA);

      preload(0, 4'hA, 8'h11); preload(0, 4'hB, 8'h22);
      push(4'hA, 8'h22);
      run_op(0, 16'h8AB0, 4, 1'b0, 0, "ld");

      preload(0, 4'hE, 8'h10); preload(0, 4'h1, 8'h30);
      push(4'hE, 8'h20); push(4'hF, 8'h01);
      run_op(0, 16'h8E17, 5, 1'b0, 0, "subn");

      preload(0, 4'h2, 8'h05); preload(0, 4'h1, 8'h80);
      push(4'h2, 8'h02); push(4'hF, 8'h01);
      run_op(0, 16'h8216, 5, 1'b0, 0, "shr vx");

      preload(1, 4'h0, 8'h03); preload(1, 4'h5, 8'hF0);
      push(4'h5, 8'h01); push(4'hF, 8'h01);
      run_op(1, 16'h8506, 5, 1'b0, 0, "quirk shr vy");

      preload(1, 4'h1, 8'h0C); preload(1, 4'h2, 8'h03);
      push(4'h1, 8'h0F); push(4'hF, 8'h00);
      run_op(1, 16'h8121, 5, 1'b0, 0, "quirk or vf0");

      preload(0, 4'h1, 8'hFF); preload(0, 4'h2, 8'h01);
      preload(0, 4'hF, 8'h55);
      drive(0, 1'b1, 16'h8124);
      @(posedge clk);
      #1 drive(0, 1'b0, 16'h8124);
      repeat (4) @(negedge clk);
      snap(0, we, wa, wd, dn, il, bz);
      chk("mid rst pre we", we, 1'b1);
      chk("mid rst pre waddr", wa, 4'h1);
      reset_n = 1'b0;
      #1;
      snap(0, we, wa, wd, dn, il, bz);
      chk("mid rst we", we, 1'b0);
      chk("mid rst busy", bz, 1'b0);
      repeat (2) @(negedge clk);
      chk("mid rst V1", rfv(0, 4'h1), 8'hFF);
      chk("mid rst VF", rfv(0, 4'hF), 8'h55);
      reset_n = 1'b1;
      @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
